// File: rtl/mp3_fifo_stream_feeder.sv
// MP3 serial data feeder: word FIFO plus a bit-clock serialiser with selectable
// bit order, request-driven pausing, flush, low-water flag and sticky underrun.
module mp3_fifo_stream_feeder #(
  parameter int WORD_BITS      = 16,
  parameter int FIFO_DEPTH     = 8,
  parameter int BIT_CLK_PERIOD = 2,
  parameter int LOW_WATER      = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          lsbFirst,
  input  logic [WORD_BITS-1:0]          dataIn,
  input  logic                          dataValid,
  output logic                          dataReady,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          lowWater,
  output logic                          underrun,
  input  logic                          underrunClear,
  output logic                          dataOut,
  output logic                          dataOutClk,
  input  logic                          dataOutReq
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int HALF = BIT_CLK_PERIOD / 2;
  localparam int PW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int CW   = $clog2(WORD_BITS);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t               state, stateNext;
  logic [PW-1:0]        presc;
  logic                 halfTick;
  logic [WORD_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wrPtr, rdPtr;
  logic                 full, empty, push, pop;
  logic                 load, shift;
  logic [WORD_BITS-1:0] shifter;
  logic [CW-1:0]        bitCnt;
  logic                 lsbLatched;
  logic                 curBit;

  assign halfTick  = (presc == PW'(HALF - 1));
  assign full      = (level == LW'(FIFO_DEPTH));
  assign empty     = (level == '0);
  assign dataReady = ~full;
  assign lowWater  = (level <= LW'(LOW_WATER));
  assign push      = dataValid && !full && !flush;
  assign pop       = load;
  assign curBit    = lsbLatched ? shifter[0] : shifter[WORD_BITS-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) presc <= '0;
    else       presc <= halfTick ? '0 : presc + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= dataIn;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_comb begin
    stateNext = state;
    load      = 1'b0;
    shift     = 1'b0;
    if (halfTick) begin
      case (state)
        IDLE: if (dataOutReq && !empty) begin
          stateNext = HIGH;
          load      = 1'b1;
        end
        HIGH: stateNext = LOW;
        LOW: begin
          // Last bit always returns to IDLE, giving one idle half-bit between words.
          if (bitCnt == '0) stateNext = IDLE;
          else if (dataOutReq) begin
            stateNext = HIGH;
            shift     = 1'b1;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
    if (flush) begin
      stateNext = IDLE;
      load      = 1'b0;
      shift     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shifter    <= '0;
      bitCnt     <= '0;
      lsbLatched <= 1'b0;
    end else begin
      state <= stateNext;
      if (load) begin
        shifter    <= mem[rdPtr];
        bitCnt     <= CW'(WORD_BITS - 1);
        lsbLatched <= lsbFirst;
      end else if (shift) begin
        shifter <= lsbLatched ? (shifter >> 1) : (shifter << 1);
        bitCnt  <= bitCnt - CW'(1);
      end
    end
  end

  // Pins follow the state register by one clock; flush forces the bit clock low at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataOut    <= 1'b0;
      dataOutClk <= 1'b0;
    end else begin
      dataOutClk <= (state == HIGH) && !flush;
      if (state == HIGH) dataOut <= curBit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                                  underrun <= 1'b0;
    else if (underrunClear)                                     underrun <= 1'b0;
    else if (halfTick && state == IDLE && dataOutReq && empty)  underrun <= 1'b1;
  end

endmodule

// File: tb/tb_mp3_fifo_stream_feeder.sv
// Bench for mp3_fifo_stream_feeder: pushed words queue their expected serial
// bits; a monitor pops and compares on every falling edge of dataOutClk.
module tb_mp3_fifo_stream_feeder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         lsbFirst = 1'b0;
  logic [W-1:0] dataIn = '0;
  logic         dataValid = 1'b0;
  logic         dataReady;
  logic [3:0]   level;
  logic         lowWater;
  logic         underrun;
  logic         underrunClear = 1'b0;
  logic         dataOut;
  logic         dataOutClk;
  logic         dataOutReq = 1'b0;

  int unsigned total = 0;
  int unsigned passed = 0;
  int unsigned bitsSeen = 0;
  logic        sbq[$];
  logic        prevClk = 1'b0;

  mp3_fifo_stream_feeder #(
    .WORD_BITS(W), .FIFO_DEPTH(8), .BIT_CLK_PERIOD(2), .LOW_WATER(2)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .lsbFirst(lsbFirst),
    .dataIn(dataIn), .dataValid(dataValid), .dataReady(dataReady),
    .level(level), .lowWater(lowWater), .underrun(underrun),
    .underrunClear(underrunClear), .dataOut(dataOut),
    .dataOutClk(dataOutClk), .dataOutReq(dataOutReq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: the decoder samples dataOut on the falling edge of dataOutClk.
  always @(negedge clk) begin
    if (!reset && prevClk && !dataOutClk) begin
      bitsSeen++;
      total++;
      if (sbq.size() == 0) begin
        $display("FAIL serialBit: got unexpected bit %0b expected none", dataOut);
      end else begin
        logic e;
        e = sbq.pop_front();
        if (dataOut === e) passed++;
        else $display("FAIL serialBit#%0d: got %0b expected %0b", bitsSeen, dataOut, e);
      end
    end
    prevClk = dataOutClk;
  end

  task automatic pushWord(input logic [W-1:0] w, input logic lsb, output logic accepted);
    @(negedge clk);
    dataIn    = w;
    dataValid = 1'b1;
    accepted  = dataReady;
    if (accepted) begin
      for (int unsigned i = 0; i < W; i++) sbq.push_back(lsb ? w[i] : w[W-1-i]);
    end
    @(negedge clk);
    dataValid = 1'b0;
  endtask

  task automatic waitDrain(input string name, input int unsigned limit);
    int unsigned n = 0;
    while (sbq.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    if (sbq.size() != 0) check({name, "_timeout"}, sbq.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic waitBits(input int unsigned target, input int unsigned limit);
    int unsigned n = 0;
    while (bitsSeen < target && n < limit) begin
      @(posedge clk);
      n++;
    end
    if (bitsSeen < target) check("waitBits_timeout", bitsSeen, target);
    @(negedge clk);
  endtask

  initial begin
    logic acc;
    int unsigned base;
    int unsigned rises;
    logic heldLow;
    logic [W-1:0] words [9];
    words = '{16'h1234, 16'h8001, 16'hFFFF, 16'h0000, 16'hC0DE,
              16'h5A5A, 16'h7E81, 16'h0F0F, 16'hDEAD};

    repeat (3) @(negedge clk);
    check("rst_level", level, 0);
    check("rst_dataReady", dataReady, 1);
    check("rst_lowWater", lowWater, 1);
    check("rst_underrun", underrun, 0);
    check("rst_dataOut", dataOut, 0);
    check("rst_dataOutClk", dataOutClk, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // MSB-first word.
    lsbFirst = 1'b0;
    pushWord(16'hA5C3, 1'b0, acc);
    check("msb_accepted", acc, 1);
    check("msb_level1", level, 1);
    dataOutReq = 1'b1;
    waitDrain("msb", 200);
    dataOutReq = 1'b0;
    check("msb_bits", bitsSeen, 16);
    check("msb_level0", level, 0);

    // LSB-first; toggling lsbFirst mid-word must not matter.
    lsbFirst = 1'b1;
    pushWord(16'hA5C3, 1'b1, acc);
    dataOutReq = 1'b1;
    repeat (10) @(negedge clk);
    lsbFirst = 1'b0;
    waitDrain("lsb", 200);
    dataOutReq = 1'b0;
    check("lsb_bits", bitsSeen, 32);

    // Fill past capacity with no requests.
    for (int i = 0; i < 9; i++) begin
      pushWord(words[i], 1'b0, acc);
      if (i == 7) begin
        check("full_dataReady", dataReady, 0);
        check("full_level", level, 8);
        check("full_lowWater", lowWater, 0);
      end
      if (i == 8) check("full_9th_rejected", acc, 0);
    end
    check("full_level_after9", level, 8);
    dataOutReq = 1'b1;
    waitDrain("full", 800);
    dataOutReq = 1'b0;
    check("full_drain_bits", bitsSeen, 32 + 8*16);
    check("full_drain_level", level, 0);

    // Pause after the 5th bit.
    base = bitsSeen;
    pushWord(16'hA5C3, 1'b0, acc);
    dataOutReq = 1'b1;
    waitBits(base + 5, 100);
    dataOutReq = 1'b0;
    repeat (4) @(negedge clk);
    heldLow = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (dataOutClk !== 1'b0) heldLow = 1'b0;
    end
    check("pause_clkHeldLow", heldLow, 1);
    dataOutReq = 1'b1;
    waitDrain("pause", 200);
    dataOutReq = 1'b0;
    check("pause_bits", bitsSeen, base + 16);

    // Underrun: set, clear beats set, stickiness.
    underrunClear = 1'b1;
    @(negedge clk);
    underrunClear = 1'b0;
    check("ur_cleared", underrun, 0);
    dataOutReq = 1'b1;
    repeat (2) @(negedge clk);
    check("ur_set", underrun, 1);
    underrunClear = 1'b1;
    @(negedge clk);
    check("ur_clearWins", underrun, 0);
    underrunClear = 1'b0;
    dataOutReq    = 1'b0;
    @(negedge clk);
    check("ur_staysClear", underrun, 0);
    dataOutReq = 1'b1;
    @(negedge clk);
    dataOutReq = 1'b0;
    repeat (5) @(negedge clk);
    check("ur_sticky", underrun, 1);

    // Flush mid-word with three words still queued.
    base = bitsSeen;
    for (int i = 0; i < 4; i++) pushWord(words[i], 1'b0, acc);
    dataOutReq = 1'b1;
    waitBits(base + 3, 100);
    dataOutReq = 1'b0;
    repeat (4) @(negedge clk);
    check("flush_levelBefore", level, 3);
    check("flush_lowWaterBefore", lowWater, 0);
    flush = 1'b1;
    sbq.delete();
    @(negedge clk);
    flush = 1'b0;
    check("flush_level", level, 0);
    check("flush_dataOutClk", dataOutClk, 0);
    check("flush_lowWater", lowWater, 1);
    check("flush_underrunKept", underrun, 1);
    dataOutReq = 1'b1;
    rises = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (dataOutClk === 1'b1) rises++;
    end
    check("flush_noClocks", rises, 0);
    base = bitsSeen;
    pushWord(16'h3C96, 1'b0, acc);
    waitDrain("postFlush", 200);
    dataOutReq = 1'b0;
    check("postFlush_bits", bitsSeen, base + 16);
    check("end_queueEmpty", sbq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL globalTimeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
